// File: rtl/pll_regbank.sv
// rtl/pll_regbank.sv - parametrised PLL config/status register bank with RO, W1C and shadowed registers
module pll_regbank #(
    parameter int                  NREGS       = 16,
    parameter int                  AW          = 8,
    parameter int                  DW          = 8,
    parameter logic [NREGS*DW-1:0] RST_VAL     = '0,
    parameter logic [NREGS*DW-1:0] WR_MASK     = '1,
    parameter logic [NREGS*DW-1:0] RD_MASK     = '1,
    parameter logic [NREGS-1:0]    RO_MAP      = '0,
    parameter logic [NREGS-1:0]    W1C_MAP     = '0,
    parameter logic [NREGS-1:0]    SHADOW_MAP  = '0,
    parameter logic [AW-1:0]       COMMIT_ADDR = AW'(8'hFF)
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic                wre,
    input  logic                rde,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       din,
    output logic [DW-1:0]       dout,
    output logic                rdvalid,
    output logic                addr_err,
    output logic                commit_pulse,
    input  logic [NREGS*DW-1:0] sts_in,
    input  logic [NREGS*DW-1:0] evt_in,
    output logic [NREGS*DW-1:0] reg_q
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic          in_range;
    logic          is_commit;
    logic          commit;
    logic          bad_access;
    logic [DW-1:0] view [NREGS];
    logic [DW-1:0] rd_sel;

    assign in_range   = {1'b0, addr} < NREGS_W;
    assign is_commit  = addr == COMMIT_ADDR;
    assign commit     = wre && is_commit && din[0];
    assign bad_access = (wre || rde) && !in_range && !is_commit;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam logic [DW-1:0] RV = RST_VAL[i*DW +: DW];
        localparam logic [DW-1:0] WM = WR_MASK[i*DW +: DW];
        localparam logic [DW-1:0] RM = RD_MASK[i*DW +: DW];

        logic wr_hit;
        logic unused_in;

        assign wr_hit    = wre && (addr == AW'(i));
        assign unused_in = ^{sts_in[i*DW +: DW], evt_in[i*DW +: DW], wr_hit};

        if (RO_MAP[i]) begin : g_ro
            assign view[i]             = sts_in[i*DW +: DW] & RM;
            assign reg_q[i*DW +: DW]   = view[i];
        end else begin : g_rw
            logic [DW-1:0] stg;
            logic [DW-1:0] nxt;

            // Event sets are ORed in after the clear so a simultaneous set wins.
            always_comb begin
                nxt = stg;
                if (W1C_MAP[i])
                    nxt = (stg & ~(din & WM & {DW{wr_hit}})) | evt_in[i*DW +: DW];
                else if (wr_hit)
                    nxt = (stg & ~WM) | (din & WM);
            end

            always_ff @(posedge sclk or negedge rstn) begin
                if (!rstn) stg <= RV;
                else       stg <= nxt;
            end

            assign view[i] = stg & RM;

            if (SHADOW_MAP[i]) begin : g_sh
                logic [DW-1:0] shd;
                always_ff @(posedge sclk or negedge rstn) begin
                    if (!rstn)       shd <= RV;
                    else if (commit) shd <= stg;
                end
                assign reg_q[i*DW +: DW] = shd;
            end else begin : g_nsh
                assign reg_q[i*DW +: DW] = stg;
            end
        end
    end

    // Unimplemented and commit addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NREGS; k++)
            if (addr == AW'(k)) rd_sel = view[k];
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            dout         <= '0;
            rdvalid      <= 1'b0;
            addr_err     <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            rdvalid      <= rde;
            addr_err     <= bad_access;
            commit_pulse <= commit;
            if (rde) dout <= rd_sel;
        end
    end

endmodule

// File: tb/tb_pll_regbank.sv
// tb/tb_pll_regbank.sv - self-checking bench for pll_regbank against a register-level model
module tb_pll_regbank;

    localparam int           N       = 16;
    localparam logic [127:0] RST_VAL = 128'h0000_0000_0000_0000_0000_0000_A500_0000;
    localparam logic [127:0] WR_MASK = {{15{8'hFF}}, 8'h1F};
    localparam logic [127:0] RD_MASK = {{15{8'hFF}}, 8'h0F};
    localparam logic [15:0]  RO_MAP  = 16'h0080;
    localparam logic [15:0]  W1C_MAP = 16'h0020;
    localparam logic [15:0]  SH_MAP  = 16'h000C;

    logic         sclk = 1'b0;
    logic         rstn = 1'b0;
    logic         wre = 1'b0, rde = 1'b0;
    logic [7:0]   addr = '0, din = '0;
    logic [7:0]   dout;
    logic         rdvalid, addr_err, commit_pulse;
    logic [127:0] sts_in = '0, evt_in = '0;
    logic [127:0] reg_q;

    int checks = 0;
    int failures = 0;

    pll_regbank #(
        .NREGS(N), .AW(8), .DW(8), .RST_VAL(RST_VAL), .WR_MASK(WR_MASK), .RD_MASK(RD_MASK),
        .RO_MAP(RO_MAP), .W1C_MAP(W1C_MAP), .SHADOW_MAP(SH_MAP), .COMMIT_ADDR(8'hFF)
    ) dut (
        .sclk(sclk), .rstn(rstn), .wre(wre), .rde(rde), .addr(addr), .din(din),
        .dout(dout), .rdvalid(rdvalid), .addr_err(addr_err), .commit_pulse(commit_pulse),
        .sts_in(sts_in), .evt_in(evt_in), .reg_q(reg_q)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: software-visible staging and datapath-visible shadow per register.
    logic [7:0] stg_m [N];
    logic [7:0] shd_m [N];
    logic [7:0] e_dout;
    logic       e_rdv, e_err, e_cp;

    function automatic logic [7:0] sw_view(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai >= N) return 8'h00;
        if (RO_MAP[ai]) return sts_in[ai*8 +: 8] & RD_MASK[ai*8 +: 8];
        return stg_m[ai] & RD_MASK[ai*8 +: 8];
    endfunction

    function automatic logic [127:0] exp_regq();
        logic [127:0] r;
        for (int i = 0; i < N; i++) begin
            if (RO_MAP[i])      r[i*8 +: 8] = sts_in[i*8 +: 8] & RD_MASK[i*8 +: 8];
            else if (SH_MAP[i]) r[i*8 +: 8] = shd_m[i];
            else                r[i*8 +: 8] = stg_m[i];
        end
        return r;
    endfunction

    always @(posedge sclk or negedge rstn) begin : model
        logic [7:0] wm, clr;
        logic       do_commit;
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                stg_m[i] = RST_VAL[i*8 +: 8];
                shd_m[i] = RST_VAL[i*8 +: 8];
            end
            e_dout = 8'h00; e_rdv = 1'b0; e_err = 1'b0; e_cp = 1'b0;
        end else begin
            e_rdv = rde;
            e_err = (wre || rde) && (addr >= 8'd16) && (addr != 8'hFF);
            if (rde) e_dout = sw_view(addr);
            do_commit = wre && (addr == 8'hFF) && din[0];
            e_cp = do_commit;
            if (do_commit)
                for (int i = 0; i < N; i++) if (SH_MAP[i]) shd_m[i] = stg_m[i];
            for (int i = 0; i < N; i++) begin
                wm = WR_MASK[i*8 +: 8];
                if (W1C_MAP[i]) begin
                    clr = (wre && int'(addr) == i) ? (din & wm) : 8'h00;
                    stg_m[i] = (stg_m[i] & ~clr) | evt_in[i*8 +: 8];
                end else if (!RO_MAP[i] && wre && int'(addr) == i) begin
                    stg_m[i] = (stg_m[i] & ~wm) | (din & wm);
                end
            end
        end
    end

    always @(negedge sclk) begin
        chk("reg_q", reg_q, exp_regq());
        chk("dout", {120'd0, dout}, {120'd0, e_dout});
        chk("rdvalid", {127'd0, rdvalid}, {127'd0, e_rdv});
        chk("addr_err", {127'd0, addr_err}, {127'd0, e_err});
        chk("commit_pulse", {127'd0, commit_pulse}, {127'd0, e_cp});
    end

    task automatic op(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                      input logic [127:0] ev);
        wre = w; rde = r; addr = a; din = d; evt_in = ev;
        @(posedge sclk);
        #1;
        wre = 1'b0; rde = 1'b0; evt_in = '0;
        @(negedge sclk);
    endtask

    logic [127:0] ev5;
    logic [127:0] exp_rst;

    initial begin
        sts_in = {{8{8'hCC}}, 8'h5A, {7{8'hCC}}};
        ev5    = (128'd1 << 40) | (128'd1 << 48);
        exp_rst = RST_VAL;
        exp_rst[63:56] = 8'h5A;

        repeat (2) @(negedge sclk);
        rstn = 1'b1;
        @(negedge sclk);
        chk("rst_reg3", {120'd0, reg_q[31:24]}, 128'hA5);
        chk("rst_rdvalid", {127'd0, rdvalid}, 128'h0);
        chk("rst_regq_all", reg_q, exp_rst);

        op(0, 1, 8'h03, 8'h00, '0);
        chk("rd3_dout", {120'd0, dout}, 128'hA5);
        chk("rd3_valid", {127'd0, rdvalid}, 128'h1);
        @(negedge sclk);
        chk("rd3_valid_drop", {127'd0, rdvalid}, 128'h0);
        chk("rd3_hold", {120'd0, dout}, 128'hA5);

        op(1, 0, 8'h00, 8'hFF, '0);
        chk("mask_regq0", {120'd0, reg_q[7:0]}, 128'h1F);
        op(0, 1, 8'h00, 8'h00, '0);
        chk("mask_rd0", {120'd0, dout}, 128'h0F);

        op(1, 0, 8'h02, 8'h12, '0);
        op(1, 0, 8'h03, 8'h34, '0);
        chk("sh_precommit", {112'd0, reg_q[31:16]}, 128'hA500);
        op(1, 0, 8'hFF, 8'h01, '0);
        chk("sh_commit", {112'd0, reg_q[31:16]}, 128'h3412);
        chk("sh_pulse", {127'd0, commit_pulse}, 128'h1);
        @(negedge sclk);
        chk("sh_pulse_drop", {127'd0, commit_pulse}, 128'h0);
        op(1, 0, 8'h02, 8'h56, '0);
        op(1, 0, 8'hFF, 8'h00, '0);
        chk("sh_din0_zero", {120'd0, reg_q[23:16]}, 128'h12);
        op(1, 0, 8'hFF, 8'h01, '0);
        chk("sh_second", {120'd0, reg_q[23:16]}, 128'h56);

        op(0, 0, 8'h00, 8'h00, ev5);
        op(0, 1, 8'h05, 8'h00, '0);
        chk("w1c_set", {120'd0, dout}, 128'h01);
        op(1, 0, 8'h05, 8'h01, ev5);
        op(0, 1, 8'h05, 8'h00, '0);
        chk("w1c_set_wins", {120'd0, dout}, 128'h01);
        op(1, 1, 8'h05, 8'h01, '0);
        chk("w1c_rd_prewrite", {120'd0, dout}, 128'h01);
        op(0, 1, 8'h05, 8'h00, '0);
        chk("w1c_cleared", {120'd0, dout}, 128'h00);

        op(0, 1, 8'h07, 8'h00, '0);
        chk("ro_rd", {120'd0, dout}, 128'h5A);
        op(1, 0, 8'h07, 8'h00, '0);
        op(0, 1, 8'h07, 8'h00, '0);
        chk("ro_wr_ignored", {120'd0, dout}, 128'h5A);
        chk("ro_regq", {120'd0, reg_q[63:56]}, 128'h5A);

        op(0, 1, 8'h20, 8'h00, '0);
        chk("err_rd_dout", {120'd0, dout}, 128'h00);
        chk("err_rd_valid", {127'd0, rdvalid}, 128'h1);
        chk("err_rd_flag", {127'd0, addr_err}, 128'h1);
        op(1, 0, 8'h20, 8'hAB, '0);
        chk("err_wr_flag", {127'd0, addr_err}, 128'h1);
        op(0, 1, 8'hFF, 8'h00, '0);
        chk("commit_rd_noerr", {127'd0, addr_err}, 128'h0);
        chk("commit_rd_dout", {120'd0, dout}, 128'h00);

        op(1, 0, 8'h02, 8'h77, '0);
        op(1, 0, 8'hFF, 8'h01, '0);
        @(posedge sclk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_regq", reg_q, exp_rst);
        chk("arst_pulse", {127'd0, commit_pulse}, 128'h0);
        @(negedge sclk);
        rstn = 1'b1;
        op(1, 0, 8'hFF, 8'h01, '0);
        chk("arst_lost", {112'd0, reg_q[31:16]}, 128'hA500);

        repeat (2) @(negedge sclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
